// File: rtl/next_pc_predictor.sv
// rtl/next_pc_predictor.sv - fetch PC register with direct-mapped BTB and gshare next-PC prediction
//
// Ports:
//   clk, reset (async, active low)       clock and reset
//   stall                                hold the fetch PC
//   current_pc / pred_taken /            registered fetch PC and its combinational
//   pred_target / pred_ghr               prediction plus the history snapshot used
//   ex_*                                 resolution of the instruction in EX
//   mispredict / redirect_pc             combinational flush request and correct next PC

module next_pc_predictor #(
    parameter int          XLEN     = 32,
    parameter int          BTB_BITS = 4,
    parameter int          PHT_BITS = 6,
    parameter int          GHR_BITS = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    output logic [XLEN-1:0]     current_pc,
    output logic                pred_taken,
    output logic [XLEN-1:0]     pred_target,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                ex_valid,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic                ex_is_branch,
    input  logic                ex_is_jal,
    input  logic                ex_is_jalr,
    input  logic                ex_bcond,
    input  logic [XLEN-1:0]     ex_target,
    input  logic                ex_pred_taken,
    input  logic [XLEN-1:0]     ex_pred_target,
    input  logic [GHR_BITS-1:0] ex_ghr,
    output logic                mispredict,
    output logic [XLEN-1:0]     redirect_pc
);

    localparam int BTB_N = 1 << BTB_BITS;
    localparam int PHT_N = 1 << PHT_BITS;
    localparam int TAG_W = XLEN - BTB_BITS - 2;

    logic [XLEN-1:0]     r_pc;
    logic [GHR_BITS-1:0] r_ghr;
    logic                r_btb_valid [BTB_N];
    logic                r_btb_jump  [BTB_N];
    logic [TAG_W-1:0]    r_btb_tag   [BTB_N];
    logic [XLEN-1:0]     r_btb_tgt   [BTB_N];
    logic [1:0]          r_pht       [PHT_N];

    logic [BTB_BITS-1:0] w_btb_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [PHT_BITS-1:0] w_pht_idx;
    logic                w_hit;
    logic                w_actual_taken;
    logic                w_train;
    logic [BTB_BITS-1:0] w_ex_btb_idx;
    logic [TAG_W-1:0]    w_ex_tag;
    logic [PHT_BITS-1:0] w_ex_pht_idx;
    logic                w_unused_pred_taken;

    // Mispredict detection compares targets only, so the piped taken bit is redundant.
    assign w_unused_pred_taken = ex_pred_taken;

    // Lookup: PC bits [1:0] never participate in indexing.
    assign w_btb_idx = r_pc[BTB_BITS+1:2];
    assign w_tag     = r_pc[XLEN-1:BTB_BITS+2];
    assign w_pht_idx = r_pc[PHT_BITS+1:2] ^ PHT_BITS'(r_ghr);
    assign w_hit     = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag);

    assign current_pc  = r_pc;
    assign pred_taken  = w_hit && (r_btb_jump[w_btb_idx] || r_pht[w_pht_idx][1]);
    assign pred_target = pred_taken ? r_btb_tgt[w_btb_idx] : r_pc + XLEN'(4);
    assign pred_ghr    = r_ghr;

    // Resolution
    assign w_actual_taken = ex_is_jal || ex_is_jalr || (ex_is_branch && ex_bcond);
    assign redirect_pc    = w_actual_taken ? ex_target : ex_pc + XLEN'(4);
    // A non-control instruction predicted taken (stale alias) is caught here too,
    // since its redirect is the fall-through PC.
    assign mispredict     = ex_valid && (ex_pred_target != redirect_pc);

    assign w_train      = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
    assign w_ex_btb_idx = ex_pc[BTB_BITS+1:2];
    assign w_ex_tag     = ex_pc[XLEN-1:BTB_BITS+2];
    assign w_ex_pht_idx = ex_pc[PHT_BITS+1:2] ^ PHT_BITS'(ex_ghr);

    // Fetch PC: redirect beats stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= XLEN'(RESET_PC);
        end else if (mispredict) begin
            r_pc <= redirect_pc;
        end else if (!stall) begin
            r_pc <= pred_target;
        end
    end

    // Training. Writes land at the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_jump[i]  <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_tgt[i]   <= '0;
            end
            for (int i = 0; i < PHT_N; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else if (w_train) begin
            if (w_actual_taken) begin
                r_btb_valid[w_ex_btb_idx] <= 1'b1;
                r_btb_jump[w_ex_btb_idx]  <= ex_is_jal || ex_is_jalr;
                r_btb_tag[w_ex_btb_idx]   <= w_ex_tag;
                r_btb_tgt[w_ex_btb_idx]   <= ex_target;
            end
            if (ex_is_branch) begin
                if (ex_bcond && (r_pht[w_ex_pht_idx] != 2'b11)) begin
                    r_pht[w_ex_pht_idx] <= r_pht[w_ex_pht_idx] + 2'b01;
                end else if (!ex_bcond && (r_pht[w_ex_pht_idx] != 2'b00)) begin
                    r_pht[w_ex_pht_idx] <= r_pht[w_ex_pht_idx] - 2'b01;
                end
                r_ghr <= (r_ghr << 1) | GHR_BITS'(ex_bcond);
            end
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// tb/tb_next_pc_predictor.sv - self-checking bench for next_pc_predictor against a behavioural model

module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] current_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [3:0]  pred_ghr;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_is_branch = 1'b0;
    logic        ex_is_jal = 1'b0;
    logic        ex_is_jalr = 1'b0;
    logic        ex_bcond = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic [3:0]  ex_ghr = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    next_pc_predictor dut (
        .clk(clk), .reset(reset), .stall(stall),
        .current_pc(current_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ghr(pred_ghr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_bcond(ex_bcond),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
    );

    // Reference model: 16-entry BTB, 64 counters as integers, history as an integer.
    logic [31:0] m_pc;
    int          m_ghr;
    bit          m_v   [16];
    bit          m_j   [16];
    logic [31:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_pht [64];
    logic        m_mp;
    logic [31:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mpred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int bi;
        int pi;
        bit hit;
        bi  = int'((pc / 4) % 16);
        pi  = int'((pc / 4) % 64) ^ m_ghr;
        hit = m_v[bi] && (m_tag[bi] == pc / 64);
        t   = hit && (m_j[bi] || m_pht[pi] >= 2);
        tg  = t ? m_tgt[bi] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ghr = 0;
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_j[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
        end
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
    endtask

    // Drive one cycle's inputs, let them settle, compare every output with the model.
    task automatic drive(input logic st, input logic v, input logic [31:0] epc,
                         input logic br, input logic jl, input logic jr, input logic bc,
                         input logic [31:0] tgt, input logic ept, input logic [31:0] eptg,
                         input logic [3:0] eg);
        logic        t;
        logic [31:0] tg;
        logic        act;
        stall = st; ex_valid = v; ex_pc = epc; ex_is_branch = br; ex_is_jal = jl;
        ex_is_jalr = jr; ex_bcond = bc; ex_target = tgt; ex_pred_taken = ept;
        ex_pred_target = eptg; ex_ghr = eg;
        #2;
        mpred(m_pc, t, tg);
        act  = jl || jr || (br && bc);
        m_rd = act ? tgt : epc + 32'd4;
        m_mp = v && (eptg != m_rd);
        chk("current_pc", current_pc, m_pc);
        chk("pred_taken", 32'(pred_taken), 32'(t));
        chk("pred_target", pred_target, tg);
        chk("pred_ghr", 32'(pred_ghr), 32'(m_ghr));
        chk("mispredict", 32'(mispredict), 32'(m_mp));
        chk("redirect_pc", redirect_pc, m_rd);
    endtask

    // Clock edge plus the model's view of what the edge does.
    task automatic commit();
        logic        t;
        logic [31:0] tg;
        bit          act;
        int          bi;
        int          pi;
        mpred(m_pc, t, tg);
        @(posedge clk);
        act = ex_is_jal || ex_is_jalr || (ex_is_branch && ex_bcond);
        if (m_mp) m_pc = m_rd;
        else if (!stall) m_pc = tg;
        if (ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
            bi = int'((ex_pc / 4) % 16);
            if (act) begin
                m_v[bi] = 1; m_j[bi] = ex_is_jal || ex_is_jalr;
                m_tag[bi] = ex_pc / 64; m_tgt[bi] = ex_target;
            end
            if (ex_is_branch) begin
                pi = int'((ex_pc / 4) % 64) ^ int'(ex_ghr);
                if (ex_bcond) m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
                else          m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
                m_ghr = ((m_ghr * 2) + int'(ex_bcond)) % 16;
            end
        end
        #1;
    endtask

    task automatic idle(input logic st);
        drive(st, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        commit();
    endtask

    // Redirect fetch to x via a non-control instruction that was mispredicted.
    task automatic goto_pc(input logic [31:0] x);
        drive(0, 1, x - 32'd4, 0, 0, 0, 0, 32'h0, 1, x + 32'h1000, m_ghr[3:0]);
        commit();
    endtask

    // Resolve the instruction at the current fetch PC, piping the model's own prediction.
    task automatic resolve_drive(input logic br, input logic jl, input logic jr,
                                 input logic bc, input logic [31:0] tgt);
        logic        t;
        logic [31:0] tg;
        mpred(m_pc, t, tg);
        drive(0, 1, m_pc, br, jl, jr, bc, tgt, t, tg, m_ghr[3:0]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        chk("rst_pc", current_pc, 32'h0);
        chk("rst_pred_taken", 32'(pred_taken), 32'h0);
        chk("rst_pred_target", pred_target, 32'h4);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pcs [6];
        model_reset();
        pcs = '{32'h40, 32'h80, 32'h50, 32'h20, 32'h44, 32'hFFFF_FFFC};

        // Reset and sequential fetch
        do_reset();
        idle(0);
        chk("seq_pc4", current_pc, 32'h4);
        idle(0);
        chk("seq_pc8", current_pc, 32'h8);

        // Stall at 0x10, then a redirect while stalled
        idle(0); idle(0);
        for (int i = 0; i < 3; i++) idle(1);
        chk("stall_hold", current_pc, 32'h10);
        drive(1, 1, 32'h60, 0, 1, 0, 0, 32'h80, 0, 32'h64, 4'h0);
        commit();
        chk("stall_redirect", current_pc, 32'h80);

        // jal cold miss then hit
        do_reset();
        goto_pc(32'h20);
        resolve_drive(0, 1, 0, 0, 32'h100);
        chk("jal_miss_mp", 32'(mispredict), 32'h1);
        chk("jal_miss_rd", redirect_pc, 32'h100);
        commit();
        goto_pc(32'h20);
        resolve_drive(0, 1, 0, 0, 32'h100);
        chk("jal_hit_taken", 32'(pred_taken), 32'h1);
        chk("jal_hit_target", pred_target, 32'h100);
        chk("jal_hit_mp", 32'(mispredict), 32'h0);
        commit();

        // Loop branch at 0x40 -> 0x30, taken 3x then exits
        do_reset();
        for (int i = 0; i < 3; i++) begin
            goto_pc(32'h40);
            resolve_drive(1, 0, 0, 1, 32'h30);
            commit();
        end
        goto_pc(32'h40);
        resolve_drive(1, 0, 0, 0, 32'h30);
        chk("loop_exit_rd", redirect_pc, 32'h44);
        commit();
        chk("loop_ghr", 32'(pred_ghr), 32'hE);

        // jalr target change
        do_reset();
        goto_pc(32'h50);
        resolve_drive(0, 0, 1, 0, 32'h200);
        commit();
        goto_pc(32'h50);
        resolve_drive(0, 0, 1, 0, 32'h300);
        chk("jalr_pred", pred_target, 32'h200);
        chk("jalr_mp", 32'(mispredict), 32'h1);
        chk("jalr_rd", redirect_pc, 32'h300);
        commit();
        goto_pc(32'h50);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        chk("jalr_updated", pred_target, 32'h300);
        commit();

        // Alias eviction and counter saturation
        do_reset();
        goto_pc(32'h40);
        resolve_drive(1, 0, 0, 1, 32'h30);
        commit();
        for (int i = 0; i < 8; i++) begin
            goto_pc(32'h80);
            resolve_drive(1, 0, 0, 1, 32'h90);
            commit();
        end
        goto_pc(32'h40);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        chk("alias_evict", 32'(pred_taken), 32'h0);
        commit();
        goto_pc(32'h80);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        chk("sat_taken", 32'(pred_taken), 32'h1);
        commit();

        // PC wraparound
        goto_pc(32'hFFFF_FFFC);
        idle(0);
        chk("wrap_pc", current_pc, 32'h0);

        // Reset asserted between edges discards a pending training write
        goto_pc(32'h20);
        drive(0, 1, 32'h20, 0, 1, 0, 0, 32'h400, 0, 32'h24, 4'h0);
        reset = 1'b0;
        #1;
        chk("midrst_pc", current_pc, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        goto_pc(32'h20);
        drive(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
        chk("midrst_btb_clear", 32'(pred_taken), 32'h0);
        commit();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] epc;
            logic [31:0] tgt;
            logic [31:0] eptg;
            logic        t;
            logic [31:0] tg;
            int          kind;
            epc  = pcs[$urandom_range(5, 0)];
            tgt  = {$urandom_range(63, 0), 2'b00} * 32'd4;
            kind = $urandom_range(4, 0);
            mpred(epc, t, tg);
            case ($urandom_range(2, 0))
                0:       eptg = tg;
                1:       eptg = epc + 32'd4;
                default: eptg = tgt;
            endcase
            drive($urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0, epc,
                  kind == 1, kind == 2, kind == 3, 1'($urandom_range(1, 0)), tgt,
                  t, eptg, 4'($urandom_range(15, 0)));
            commit();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
